// File: rtl/fp8_mul_sched.sv
// fp8_mul_sched -- issues FP8 vector-multiply requests from two requesters
// onto one shared, pipelined FP8VectorMul and returns each result to the
// requester that issued it, in issue order.
//
// Parameters:
//   MUL_LATENCY  cycles from operands on mul_* to the matching mul_res (1..8)
//   FIFO_DEPTH   response FIFO entries per requester (power of two, 2..16)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_N / req_ready_N     request handshake, requester N (0/1)
//   req_q_N, req_vec_N            FP8 scalar and four FP8 lanes {d,c,b,a}
//   req_e5m2_N                    1 = E5M2, 0 = E4M3
//   rsp_valid_N / rsp_ready_N     response handshake, requester N
//   rsp_res_N                     four FP16 products {qd,qc,qb,qa}
//   mul_q, mul_vec, mul_e5m2mode  registered operands to the shared multiplier
//   mul_res                       shared multiplier result
//   busy                          work in flight or a response FIFO non-empty
//
// Handshake: a request (response) transfers on a rising edge where its valid
// and ready are both high. req_ready_N may depend combinationally on
// req_valid_N; rsp_valid_N never depends on rsp_ready_N, and rsp_res_N holds
// steady while rsp_valid_N is high and rsp_ready_N is low.
//
// Build option: define FP8_SCHED_FIXED_PRIO_EN to give requester 0 fixed
// priority; otherwise contention is resolved round-robin.
module fp8_mul_sched #(
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [7:0]  req_q_0,
  input  logic [7:0]  req_q_1,
  input  logic [31:0] req_vec_0,
  input  logic [31:0] req_vec_1,
  input  logic        req_e5m2_0,
  input  logic        req_e5m2_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [63:0] rsp_res_0,
  output logic [63:0] rsp_res_1,
  output logic [7:0]  mul_q,
  output logic [31:0] mul_vec,
  output logic        mul_e5m2mode,
  input  logic [63:0] mul_res,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  logic [1:0]    req_valid;
  logic [1:0]    rsp_ready;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [CW-1:0] credit [2];
  logic [CW-1:0] wr_ptr [2];
  logic [CW-1:0] rd_ptr [2];
  logic [63:0]   mem [2][FIFO_DEPTH];
  // tag_q[0] is aligned with the mul_* register; tag_q[MUL_LATENCY] lines up
  // with the cycle in which mul_res carries that operation's result.
  tag_t          tag_q [MUL_LATENCY+1];
  tag_t          tag_out;
  logic          last_grant;

  assign req_valid = {req_valid_1, req_valid_0};
  assign rsp_ready = {rsp_ready_1, rsp_ready_0};
  assign tag_out   = tag_q[MUL_LATENCY];

  // Credit counts in-flight work plus FIFO occupancy, so a granted request
  // always has a FIFO slot waiting when its result comes out.
  always_comb begin
    elig  = 2'b00;
    empty = 2'b00;
    full  = 2'b00;
    push  = 2'b00;
    pop   = 2'b00;
    for (int r = 0; r < 2; r++) begin
      elig[r]  = req_valid[r] && (credit[r] < DEPTH_C) && !rst;
      empty[r] = (wr_ptr[r] == rd_ptr[r]);
      full[r]  = ((wr_ptr[r] - rd_ptr[r]) == DEPTH_C);
      push[r]  = tag_out.v && (tag_out.id == r[0]);
      pop[r]   = rsp_ready[r] && !empty[r];
    end
  end

  always_comb begin
    grant = 2'b00;
`ifdef FP8_SCHED_FIXED_PRIO_EN
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
`else
    // last_grant = 1 means requester 1 went last, so requester 0 is favoured.
    if (elig == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
`endif
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign rsp_valid_0 = !empty[0];
  assign rsp_valid_1 = !empty[1];
  assign rsp_res_0   = empty[0] ? '0 : mem[0][rd_ptr[0][AW-1:0]];
  assign rsp_res_1   = empty[1] ? '0 : mem[1][rd_ptr[1][AW-1:0]];
  assign busy        = (credit[0] != '0) || (credit[1] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        credit[r] <= '0;
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
      end
      for (int k = 0; k <= MUL_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
      last_grant   <= 1'b1;
      mul_q        <= '0;
      mul_vec      <= '0;
      mul_e5m2mode <= 1'b0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        credit[r] <= credit[r] + CW'(grant[r]) - CW'(pop[r]);
        if (push[r]) wr_ptr[r] <= wr_ptr[r] + 1'b1;
        if (pop[r])  rd_ptr[r] <= rd_ptr[r] + 1'b1;
      end
      tag_q[0] <= '{v: |grant, id: grant[1]};
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (|grant) begin
        last_grant   <= grant[1];
        mul_q        <= grant[1] ? req_q_1    : req_q_0;
        mul_vec      <= grant[1] ? req_vec_1  : req_vec_0;
        mul_e5m2mode <= grant[1] ? req_e5m2_1 : req_e5m2_0;
      end
    end
  end

  // Storage only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (!rst && push[r]) mem[r][wr_ptr[r][AW-1:0]] <= mul_res;
    end
  end

  // Credit accounting makes a push into a full FIFO without a pop impossible.
  a_no_overflow_0: assert property (@(posedge clk) disable iff (rst)
    !(push[0] && full[0] && !pop[0]));
  a_no_overflow_1: assert property (@(posedge clk) disable iff (rst)
    !(push[1] && full[1] && !pop[1]));

endmodule

// File: tb/tb_fp8_mul_sched.sv
// Directed bench for fp8_mul_sched. A behavioural stand-in for the shared
// FP8VectorMul (fixed latency, deterministic function) feeds mul_res; a
// scoreboard holds the expected response sequence per requester.
module tb_fp8_mul_sched;

  localparam int L = 1;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_0 = 0, req_valid_1 = 0;
  logic        req_ready_0, req_ready_1;
  logic [7:0]  req_q_0 = '0, req_q_1 = '0;
  logic [31:0] req_vec_0 = '0, req_vec_1 = '0;
  logic        req_e5m2_0 = 0, req_e5m2_1 = 0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [63:0] rsp_res_0, rsp_res_1;
  logic [7:0]  mul_q;
  logic [31:0] mul_vec;
  logic        mul_e5m2mode;
  logic [63:0] mul_res;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  fp8_mul_sched #(.MUL_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_q_0(req_q_0), .req_q_1(req_q_1),
    .req_vec_0(req_vec_0), .req_vec_1(req_vec_1),
    .req_e5m2_0(req_e5m2_0), .req_e5m2_1(req_e5m2_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_res_0(rsp_res_0), .rsp_res_1(rsp_res_1),
    .mul_q(mul_q), .mul_vec(mul_vec), .mul_e5m2mode(mul_e5m2mode),
    .mul_res(mul_res), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- multiplier stand-in ----------------
  // The one vector with hand-worked FP16 products returns those; any other
  // operand set returns a distinct deterministic pattern.
  function automatic logic [63:0] mul_model(input logic [7:0] q,
                                            input logic [31:0] vec,
                                            input logic e5);
    if (q == 8'h3C && vec == 32'hC840C43C && !e5)
      return 64'hC6004200C4804080;
    return {vec ^ {q, q, q, q}, vec + {23'd0, e5, q}};
  endfunction

  logic [63:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= mul_model(mul_q, mul_vec, mul_e5m2mode);
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_res = mpipe[L-1];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (req_valid_0 && req_ready_0) exp_q0.push_back(mul_model(req_q_0, req_vec_0, req_e5m2_0));
      if (req_valid_1 && req_ready_1) exp_q1.push_back(mul_model(req_q_1, req_vec_1, req_e5m2_1));
      if (rsp_valid_0 && rsp_ready_0) begin
        tests_run++;
        if (exp_q0.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp0_unexpected got=%h expected=none", rsp_res_0);
        end else begin
          e = exp_q0.pop_front();
          if (rsp_res_0 !== e) begin
            tests_failed++;
            $display("FAIL rsp0_data got=%h expected=%h", rsp_res_0, e);
          end
        end
      end
      if (rsp_valid_1 && rsp_ready_1) begin
        tests_run++;
        if (exp_q1.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp1_unexpected got=%h expected=none", rsp_res_1);
        end else begin
          e = exp_q1.pop_front();
          if (rsp_res_1 !== e) begin
            tests_failed++;
            $display("FAIL rsp1_data got=%h expected=%h", rsp_res_1, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && busy !== 1'b0; k++) step();
    step();
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain busy=%b expected=0", name, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    step();
    step();
    tests_run++;
    if ({req_ready_1, req_ready_0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready_in_rst got=%b expected=00", {req_ready_1, req_ready_0});
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0, mul_e5m2mode, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b expected=000000",
               {req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0, mul_e5m2mode, busy});
    end
    tests_run++;
    if (rsp_res_0 !== 64'd0 || rsp_res_1 !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_rsp_res got=%h/%h expected=0", rsp_res_0, rsp_res_1);
    end
    tests_run++;
    if (mul_q !== 8'd0 || mul_vec !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mul_ops got=%h/%h expected=0", mul_q, mul_vec);
    end
  endtask

  task automatic test_single_op();
    rsp_ready_0 = 1'b0;
    req_valid_0 = 1'b1;
    req_q_0 = 8'h3C;
    req_vec_0 = 32'hC840C43C;
    req_e5m2_0 = 1'b0;
    #1;
    tests_run++;
    if (req_ready_0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready got=%b expected=1", req_ready_0);
    end
    step();  // transfer edge E
    req_valid_0 = 1'b0;
    tests_run++;
    if (mul_q !== 8'h3C || mul_vec !== 32'hC840C43C || mul_e5m2mode !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_mul_ops got=%h/%h/%b expected=3c/c840c43c/0", mul_q, mul_vec, mul_e5m2mode);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy got=%b expected=1", busy);
    end
    for (int k = 0; k <= L; k++) begin
      tests_run++;
      if (rsp_valid_0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_early_valid edge=E+%0d got=%b expected=0", k, rsp_valid_0);
      end
      if (k < L) step();
    end
    step();  // edge E+L+1
    tests_run++;
    if (rsp_valid_0 !== 1'b1 || rsp_res_0 !== 64'hC6004200C4804080) begin
      tests_failed++;
      $display("FAIL single_result got=%b/%h expected=1/c6004200c4804080", rsp_valid_0, rsp_res_0);
    end
    rsp_ready_0 = 1'b1;
    step();
    rsp_ready_0 = 1'b0;
    tests_run++;
    if (rsp_valid_0 !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_consumed got=%b/%b expected=0/0", rsp_valid_0, busy);
    end
  endtask

  task automatic test_contention();
    int sent0 = 0;
    int sent1 = 0;
    int idx = 0;
    logic g, exp_g;
    do_reset();
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    for (int cyc = 0; cyc < 60 && (sent0 < 8 || sent1 < 8); cyc++) begin
      req_valid_0 = (sent0 < 8);
      req_q_0 = 8'h20 + 8'(sent0);
      req_vec_0 = {4{8'h40 + 8'(sent0)}};
      req_e5m2_0 = (sent0 % 2 == 1);
      req_valid_1 = (sent1 < 8);
      req_q_1 = 8'h60 + 8'(sent1);
      req_vec_1 = {4{8'h90 + 8'(sent1)}};
      req_e5m2_1 = (sent1 % 2 == 0);
      #1;
      if (req_valid_0 && req_valid_1) begin
        tests_run++;
        if ((req_ready_0 ^ req_ready_1) !== 1'b1) begin
          tests_failed++;
          $display("FAIL contention_one_grant cyc=%0d got=%b%b expected one-hot", cyc, req_ready_1, req_ready_0);
        end
      end
      if (req_ready_0 || req_ready_1) begin
        g = req_ready_1;
`ifdef FP8_SCHED_FIXED_PRIO_EN
        exp_g = (idx >= 8);
`else
        exp_g = (idx % 2 == 1);
`endif
        tests_run++;
        if (g !== exp_g) begin
          tests_failed++;
          $display("FAIL contention_order grant#%0d got=%b expected=%b", idx, g, exp_g);
        end
        idx++;
        if (g) sent1++;
        else   sent0++;
      end
      step();
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    tests_run++;
    if (idx != 16) begin
      tests_failed++;
      $display("FAIL contention_count got=%0d expected=16", idx);
    end
    wait_idle("contention");
  endtask

  task automatic test_backpressure();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b1;
    for (int i = 0; i < D + 4; i++) begin
      req_valid_0 = 1'b1;
      req_q_0 = 8'h80 + 8'(i);
      req_vec_0 = {4{8'h11 * 8'(i + 1)}};
      req_e5m2_0 = 1'b0;
      #1;
      tests_run++;
      if (req_ready_0 !== (i < D)) begin
        tests_failed++;
        $display("FAIL backpressure_ready cyc=%0d got=%b expected=%b", i, req_ready_0, (i < D));
      end
      step();
    end
    req_valid_1 = 1'b1;
    req_q_1 = 8'h55;
    req_vec_1 = 32'h01020304;
    req_e5m2_1 = 1'b1;
    #1;
    tests_run++;
    if ({req_ready_1, req_ready_0} !== 2'b10) begin
      tests_failed++;
      $display("FAIL backpressure_req1_served got=%b%b expected=10", req_ready_1, req_ready_0);
    end
    step();
    req_valid_1 = 1'b0;
    for (int k = 0; k < L + 2; k++) step();
  endtask

  task automatic test_full_pop_accept();
    // Requester 0 still valid, FIFO full, credit at the limit.
    rsp_ready_0 = 1'b1;
    req_q_0 = 8'hA0;
    req_vec_0 = 32'hA0A1A2A3;
    #1;
    tests_run++;
    if (req_ready_0 !== 1'b0 || rsp_valid_0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_start got=%b/%b expected=0/1", req_ready_0, rsp_valid_0);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      req_q_0 = 8'hA1 + 8'(i);
      req_vec_0 = {4{8'hB0 + 8'(i)}};
      #1;
      tests_run++;
      if (req_ready_0 !== 1'b1 || rsp_valid_0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_pop_accept cyc=%0d got=%b/%b expected=1/1", i, req_ready_0, rsp_valid_0);
      end
      step();
    end
    rsp_ready_0 = 1'b0;
    req_q_0 = 8'hC0;
    req_vec_0 = 32'hCAFEF00D;
    #1;
    tests_run++;
    if (req_ready_0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_last_slot got=%b expected=1", req_ready_0);
    end
    step();
    tests_run++;
    if (req_ready_0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_refilled got=%b expected=0", req_ready_0);
    end
    req_valid_0 = 1'b0;
    rsp_ready_0 = 1'b1;
    wait_idle("full");
  endtask

  task automatic test_reset_midflight();
    rsp_ready_0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid_0 = 1'b1;
      req_q_0 = 8'hE0 + 8'(i);
      req_vec_0 = {4{8'h70 + 8'(i)}};
      req_e5m2_0 = 1'b1;
      #1;
      tests_run++;
      if (req_ready_0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL midreset_issue cyc=%0d got=%b expected=1", i, req_ready_0);
      end
      step();
    end
    req_valid_0 = 1'b0;
    rst = 1'b1;
    step();
    tests_run++;
    if ({rsp_valid_1, rsp_valid_0, busy, mul_e5m2mode, req_ready_1, req_ready_0} !== 6'b0) begin
      tests_failed++;
      $display("FAIL midreset_flags got=%b expected=000000",
               {rsp_valid_1, rsp_valid_0, busy, mul_e5m2mode, req_ready_1, req_ready_0});
    end
    tests_run++;
    if (mul_q !== 8'd0 || mul_vec !== 32'd0 || rsp_res_0 !== 64'd0) begin
      tests_failed++;
      $display("FAIL midreset_values got=%h/%h/%h expected=0", mul_q, mul_vec, rsp_res_0);
    end
    exp_q0.delete();
    exp_q1.delete();
    rst = 1'b0;
    rsp_ready_0 = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      step();
      tests_run++;
      if (rsp_valid_0 !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stale cyc=%0d got=%b/%b expected=0/0", k, rsp_valid_0, busy);
      end
    end
  endtask

  task automatic test_e5m2_toggle();
    logic [3:0] e5_pat;
    e5_pat = 4'b1101;
    rsp_ready_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid_0 = 1'b1;
      req_q_0 = 8'h31 + 8'(i);
      req_vec_0 = {4{8'h5A ^ 8'(i)}};
      req_e5m2_0 = e5_pat[i];
      #1;
      tests_run++;
      if (req_ready_0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL e5m2_ready cyc=%0d got=%b expected=1", i, req_ready_0);
      end
      step();
      tests_run++;
      if (mul_e5m2mode !== e5_pat[i] || mul_q !== 8'h31 + 8'(i)) begin
        tests_failed++;
        $display("FAIL e5m2_issue cyc=%0d got=%b/%h expected=%b/%h", i, mul_e5m2mode, mul_q, e5_pat[i], 8'h31 + 8'(i));
      end
    end
    req_valid_0 = 1'b0;
    step();
    step();
    tests_run++;
    if (mul_q !== 8'h34 || mul_vec !== {4{8'h59}} || mul_e5m2mode !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_hold got=%h/%h/%b expected=34/59595959/1", mul_q, mul_vec, mul_e5m2mode);
    end
    wait_idle("e5m2");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_full_pop_accept();
    test_reset_midflight();
    test_e5m2_toggle();
    tests_run++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover_expected got=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
